// File: rtl/vc_rand_delay_ctrl.sv
// rtl/vc_rand_delay_ctrl.sv - val/rdy controller inserting xorshift-random stalls between messages
// Optional per-block statistics counters are enabled by defining VC_RAND_DELAY_CTRL_STATS_EN.
module vc_rand_delay_ctrl #(
  parameter int          p_msg_nbits   = 8,
  parameter int          p_delay_nbits = 2,
  parameter logic [31:0] p_seed        = 32'h00000001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_msg_nbits-1:0] out_msg
`ifdef VC_RAND_DELAY_CTRL_STATS_EN
  ,
  output logic [31:0]            num_msgs,
  output logic [31:0]            num_stalls
`endif
);

  // An all-zero xorshift state would lock up, so a zero seed is remapped.
  localparam logic [31:0] c_seed = (p_seed == 32'h0) ? 32'h00000001 : p_seed;

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [p_delay_nbits-1:0] count_q, count_d;
  logic [31:0]              rng_q, rng_d;
  logic [p_delay_nbits-1:0] draw;
  logic                     is_pass;
  logic                     xfer;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // While reset is low the block behaves as if in PASS so traffic is never blocked.
  assign is_pass = (state_q == ST_PASS) || !reset;
  assign out_val = is_pass && in_val;
  assign in_rdy  = is_pass && out_rdy;
  assign out_msg = in_msg;
  assign xfer    = is_pass && in_val && out_rdy;
  assign draw    = rng_q[p_delay_nbits-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rng_d   = rng_q;
    if (state_q == ST_WAIT) begin
      count_d = count_q - 1'b1;
      if (count_q == p_delay_nbits'(1)) begin
        state_d = ST_PASS;
      end
    end else if (xfer && en) begin
      rng_d = xorshift32(rng_q);
      if (draw != '0) begin
        state_d = ST_WAIT;
        count_d = draw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_PASS;
      count_q <= '0;
      rng_q   <= c_seed;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rng_q   <= rng_d;
    end
  end

`ifdef VC_RAND_DELAY_CTRL_STATS_EN
  logic [31:0] num_msgs_q, num_msgs_d;
  logic [31:0] num_stalls_q, num_stalls_d;

  always_comb begin
    num_msgs_d   = num_msgs_q;
    num_stalls_d = num_stalls_q;
    if (xfer) begin
      num_msgs_d = num_msgs_q + 32'd1;
    end
    if (state_q == ST_WAIT) begin
      num_stalls_d = num_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      num_msgs_q   <= '0;
      num_stalls_q <= '0;
    end else begin
      num_msgs_q   <= num_msgs_d;
      num_stalls_q <= num_stalls_d;
    end
  end

  assign num_msgs   = num_msgs_q;
  assign num_stalls = num_stalls_q;
`endif

endmodule

// File: tb/tb_vc_rand_delay_ctrl.sv
// tb/tb_vc_rand_delay_ctrl.sv - directed self-checking bench for vc_rand_delay_ctrl
// Two instances (seed 1 and seed 3) share the same upstream/downstream stimulus.
module tb_vc_rand_delay_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       in_val;
  logic       out_rdy;
  logic [7:0] in_msg;

  logic       in_rdy_a, out_val_a;
  logic [7:0] out_msg_a;
  logic       in_rdy_b, out_val_b;
  logic [7:0] out_msg_b;
`ifdef VC_RAND_DELAY_CTRL_STATS_EN
  logic [31:0] num_msgs_a, num_stalls_a, num_msgs_b, num_stalls_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vc_rand_delay_ctrl #(.p_msg_nbits(8), .p_delay_nbits(2), .p_seed(32'h00000001)) dut (
    .clk(clk), .reset(reset), .en(en),
    .in_val(in_val), .in_rdy(in_rdy_a), .in_msg(in_msg),
    .out_val(out_val_a), .out_rdy(out_rdy), .out_msg(out_msg_a)
`ifdef VC_RAND_DELAY_CTRL_STATS_EN
    , .num_msgs(num_msgs_a), .num_stalls(num_stalls_a)
`endif
  );

  vc_rand_delay_ctrl #(.p_msg_nbits(8), .p_delay_nbits(2), .p_seed(32'h00000003)) dut3 (
    .clk(clk), .reset(reset), .en(en),
    .in_val(in_val), .in_rdy(in_rdy_b), .in_msg(in_msg),
    .out_val(out_val_b), .out_rdy(out_rdy), .out_msg(out_msg_b)
`ifdef VC_RAND_DELAY_CTRL_STATS_EN
    , .num_msgs(num_msgs_b), .num_stalls(num_stalls_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; in_val = 1'b1; out_rdy = 1'b1; in_msg = 8'hA5;

    // Scenario 1 and 2: continuous traffic, seed 1 and seed 3 side by side.
    do_reset();
    #2;
    check_eq("s1_c0_out_val", {31'd0, out_val_a}, 32'd1);
    check_eq("s1_c0_out_msg", {24'd0, out_msg_a}, 32'h000000A5);
    check_eq("s2_c0_out_val", {31'd0, out_val_b}, 32'd1);
    tick(); #2;
    check_eq("s1_c1_out_val", {31'd0, out_val_a}, 32'd0);
    check_eq("s1_c1_in_rdy", {31'd0, in_rdy_a}, 32'd0);
    check_eq("s1_c1_rng", dut.rng_q, 32'h00042021);
    check_eq("s2_c1_out_val", {31'd0, out_val_b}, 32'd0);
    check_eq("s2_c1_rng", dut3.rng_q, 32'h000C6063);
    tick(); #2;
    check_eq("s1_c2_out_val", {31'd0, out_val_a}, 32'd1);
    check_eq("s2_c2_out_val", {31'd0, out_val_b}, 32'd0);
    tick(); #2;
    check_eq("s1_c3_out_val", {31'd0, out_val_a}, 32'd0);
    check_eq("s1_c3_rng", dut.rng_q, 32'h04080601);
    check_eq("s2_c3_out_val", {31'd0, out_val_b}, 32'd0);
    tick(); #2;
    check_eq("s1_c4_out_val", {31'd0, out_val_a}, 32'd1);
    check_eq("s2_c4_out_val", {31'd0, out_val_b}, 32'd1);

    // Scenario 3: en=0 gives full throughput and freezes the RNG.
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_msg = 8'(i);
      #2;
      check_eq($sformatf("s3_out_val_%0d", i), {31'd0, out_val_a & in_rdy_a}, 32'd1);
      check_eq($sformatf("s3_out_msg_%0d", i), {24'd0, out_msg_a}, i);
      tick();
    end
    check_eq("s3_rng_frozen", dut.rng_q, 32'h00000001);
    en = 1'b1;
    #2;
    check_eq("s3_en_xfer", {31'd0, out_val_a}, 32'd1);
    tick(); #2;
    check_eq("s3_en_stall", {31'd0, out_val_a}, 32'd0);
    check_eq("s3_en_rng", dut.rng_q, 32'h00042021);

    // Scenario 4: backpressure in PASS holds state and RNG.
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq($sformatf("s4_in_rdy_%0d", i), {31'd0, in_rdy_a}, 32'd0);
      check_eq($sformatf("s4_out_val_%0d", i), {31'd0, out_val_a}, 32'd1);
      tick();
    end
    check_eq("s4_rng_held", dut.rng_q, 32'h00000001);
    out_rdy = 1'b1;
    #2;
    check_eq("s4_xfer_in_rdy", {31'd0, in_rdy_a}, 32'd1);
    tick(); #2;
    check_eq("s4_after_stall", {31'd0, out_val_a}, 32'd0);
    check_eq("s4_after_rng", dut.rng_q, 32'h00042021);

    // Scenario 5: reset while dut3 is in WAIT with count 2.
    do_reset();
    tick();
    tick();
    reset = 1'b0;
    #2;
    check_eq("s5_transparent", {31'd0, out_val_b}, 32'd1);
    tick();
    reset = 1'b1;
    #2;
    check_eq("s5_pass_out_val", {31'd0, out_val_b}, 32'd1);
    check_eq("s5_seed_reload", dut3.rng_q, 32'h00000003);
    check_eq("s5_seed1_reload", dut.rng_q, 32'h00000001);
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      check_eq($sformatf("s5_replay_%0d", i), {31'd0, out_val_b}, (i == 3) ? 32'd1 : 32'd0);
    end

`ifdef VC_RAND_DELAY_CTRL_STATS_EN
    // Scenario 6: counters over 10 cycles of scenario-1 traffic.
    begin
      int hs;
      int st;
      hs = 0;
      st = 0;
      do_reset();
      #2;
      check_eq("s6_reset_msgs", num_msgs_a, 32'd0);
      check_eq("s6_reset_stalls", num_stalls_a, 32'd0);
      for (int i = 0; i < 10; i++) begin
        if (out_val_a && out_rdy) hs++;
        else st++;
        tick(); #2;
      end
      check_eq("s6_num_msgs", num_msgs_a, hs);
      check_eq("s6_num_stalls", num_stalls_a, st);
      check_eq("s6_msgs_hand", num_msgs_a, 32'd5);
      check_eq("s6_stalls_hand", num_stalls_a, 32'd5);
      check_eq("s6_sum", num_msgs_a + num_stalls_a, 32'd10);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
